corral_input_ctrl: RTL and testbench

- Player-side front end for the corral game FSM; produces the game's `enter`/`move` inputs and consumes its `ready`/`gameover` outputs.
- Synchronises and debounces three raw push-buttons: up, down, go.
- Maintains the selected move value (saturating range).
- Runs the enter handshake: raise `enter`, wait for `ready` to fall, release `enter`.
- Times out and flags the move as rejected when the game does not accept it.

---
 rtl/corral_input_ctrl.sv | 150 +++++++++++++++
 tb/tb_corral_input_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/corral_input_ctrl.sv
// Player-side front end for the corral game: conditions three push-buttons,
// keeps the selected move and runs the enter/ready submission handshake.
module corral_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned MOVE_MIN        = 1,
  parameter int unsigned MOVE_MAX        = 5,
  parameter int unsigned ACK_TIMEOUT     = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_go,
  input  logic       ready,
  input  logic       gameover,
  output logic [2:0] move,
  output logic       enter,
  output logic       rejected,
  output logic       busy
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [2:0]    MOVE_LO  = 3'(MOVE_MIN);
  localparam logic [2:0]    MOVE_HI  = 3'(MOVE_MAX);

  localparam int unsigned UP = 0;
  localparam int unsigned DN = 1;
  localparam int unsigned GO = 2;

  typedef enum logic [1:0] {
    ST_SELECT,
    ST_PRESENT,
    ST_RELEASE,
    ST_REJECT
  } state_t;

  logic [2:0]         raw;
  logic [2:0]         sync1_q, sync1_d;
  logic [2:0]         sync2_q, sync2_d;
  logic [2:0]         db_q, db_d;
  logic [2:0]         db_prev_q, db_prev_d;
  logic [2:0][DW-1:0] cnt_q, cnt_d;
  logic [2:0]         press;

  state_t     state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0] move_q, move_d;
  logic       enter_q, enter_d;
  logic       rejected_q, rejected_d;
  logic       busy_q, busy_d;
  logic       gameover_q, gameover_d;

  assign raw = {btn_go, btn_down, btn_up};

  // Debounced level moves when the counter would reach DEBOUNCE_CYCLES-1.
  always_comb begin
    sync1_d   = raw;
    sync2_d   = sync1_q;
    db_d      = db_q;
    db_prev_d = db_q;
    cnt_d     = cnt_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] + DW'(1) == DB_LAST) begin
        db_d[i]  = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DW'(1);
      end
    end
  end

  assign press = db_q & ~db_prev_q;

  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    move_d     = move_q;
    gameover_d = gameover;
    case (state_q)
      ST_SELECT: begin
        // Leaving SELECT freezes move so it is stable a clock before enter rises.
        if (press[GO] && ready) begin
          state_d = ST_PRESENT;
          tcnt_d  = '0;
        end else if (press[UP] && !press[DN]) begin
          if (move_q < MOVE_HI) move_d = move_q + 3'd1;
        end else if (press[DN] && !press[UP]) begin
          if (move_q > MOVE_LO) move_d = move_q - 3'd1;
        end
      end
      ST_PRESENT: begin
        if (!ready) begin
          state_d = ST_RELEASE;
        end else if (tcnt_q == TO_LAST) begin
          state_d = ST_REJECT;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_RELEASE: state_d = ST_SELECT;
      ST_REJECT:  state_d = ST_SELECT;
      default:    state_d = ST_SELECT;
    endcase
    if (gameover && !gameover_q) move_d = MOVE_LO;
    enter_d    = (state_d == ST_PRESENT);
    rejected_d = (state_d == ST_REJECT);
    busy_d     = (state_d != ST_SELECT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_q       <= '0;
      db_prev_q  <= '0;
      cnt_q      <= '0;
      state_q    <= ST_SELECT;
      tcnt_q     <= '0;
      move_q     <= MOVE_LO;
      enter_q    <= 1'b0;
      rejected_q <= 1'b0;
      busy_q     <= 1'b0;
      gameover_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_q       <= db_d;
      db_prev_q  <= db_prev_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      move_q     <= move_d;
      enter_q    <= enter_d;
      rejected_q <= rejected_d;
      busy_q     <= busy_d;
      gameover_q <= gameover_d;
    end
  end

  assign move     = move_q;
  assign enter    = enter_q;
  assign rejected = rejected_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_corral_input_ctrl.sv
// Directed bench for corral_input_ctrl with DEBOUNCE_CYCLES=4, ACK_TIMEOUT=8.
module tb_corral_input_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       btn_up, btn_down, btn_go;
  logic       ready, gameover;
  logic [2:0] move;
  logic       enter, rejected, busy;

  int unsigned tests_run = 0;
  int unsigned fails     = 0;

  corral_input_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .MOVE_MIN(1),
    .MOVE_MAX(5),
    .ACK_TIMEOUT(8)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_go(btn_go),
    .ready(ready),
    .gameover(gameover),
    .move(move),
    .enter(enter),
    .rejected(rejected),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; btn_up = 0; btn_down = 0; btn_go = 0;
    ready = 1'b1; gameover = 1'b0;
    tick(); tick();
    tests_run++;
    if (move !== 3'd1 || enter !== 1'b0 || rejected !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset: move=%0d enter=%b rejected=%b busy=%b, expected 1 0 0 0",
               move, enter, rejected, busy);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_up_presses();
    logic [2:0] exp_move;
    exp_move = 3'd1;
    for (int k = 0; k < 3; k++) begin
      btn_up = 1'b1;
      repeat (5) tick();
      tests_run++;
      if (move !== exp_move) begin
        fails++;
        $display("FAIL up_early[%0d]: move=%0d expected %0d", k, move, exp_move);
      end
      tick();
      exp_move = exp_move + 3'd1;
      tests_run++;
      if (move !== exp_move || enter !== 1'b0) begin
        fails++;
        $display("FAIL up_edge6[%0d]: move=%0d enter=%b expected %0d 0", k, move, enter, exp_move);
      end
      btn_up = 1'b0;
      repeat (8) tick();
    end
  endtask

  task automatic test_saturation();
    int exp_move;
    exp_move = 4;
    for (int k = 0; k < 7; k++) begin
      btn_up = 1'b1; repeat (6) tick(); btn_up = 1'b0; repeat (8) tick();
      exp_move = (exp_move < 5) ? exp_move + 1 : 5;
      tests_run++;
      if (move !== 3'(exp_move)) begin
        fails++;
        $display("FAIL sat_up[%0d]: move=%0d expected %0d", k, move, exp_move);
      end
    end
    for (int k = 0; k < 9; k++) begin
      btn_down = 1'b1; repeat (6) tick(); btn_down = 1'b0; repeat (8) tick();
      exp_move = (exp_move > 1) ? exp_move - 1 : 1;
      tests_run++;
      if (move !== 3'(exp_move)) begin
        fails++;
        $display("FAIL sat_down[%0d]: move=%0d expected %0d", k, move, exp_move);
      end
    end
  endtask

  task automatic test_glitch();
    btn_up = 1'b1; repeat (2) tick(); btn_up = 1'b0;
    repeat (10) tick();
    tests_run++;
    if (move !== 3'd1) begin
      fails++;
      $display("FAIL glitch: move=%0d expected 1", move);
    end
  endtask

  task automatic test_handshake();
    int high_cnt;
    ready = 1'b1;
    btn_go = 1'b1;
    repeat (5) tick();
    tests_run++;
    if (enter !== 1'b0) begin
      fails++;
      $display("FAIL hs_pre: enter=%b expected 0", enter);
    end
    tick();
    btn_go = 1'b0;
    tests_run++;
    if (enter !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL hs_rise: enter=%b busy=%b expected 1 1", enter, busy);
    end
    high_cnt = 1;
    tick(); if (enter === 1'b1) high_cnt++;
    tick(); if (enter === 1'b1) high_cnt++;
    ready = 1'b0;
    tick(); if (enter === 1'b1) high_cnt++;
    tests_run++;
    if (high_cnt != 3 || enter !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL hs_release: high_cnt=%0d enter=%b busy=%b expected 3 0 1", high_cnt, enter, busy);
    end
    tick();
    tests_run++;
    if (busy !== 1'b0 || move !== 3'd1 || rejected !== 1'b0) begin
      fails++;
      $display("FAIL hs_done: busy=%b move=%0d rejected=%b expected 0 1 0", busy, move, rejected);
    end
    ready = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_timeout();
    int high_cnt;
    ready = 1'b1;
    btn_go = 1'b1;
    repeat (6) tick();
    btn_go = 1'b0;
    high_cnt = (enter === 1'b1) ? 1 : 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (enter === 1'b1) high_cnt++;
      else break;
    end
    tests_run++;
    if (high_cnt != 8) begin
      fails++;
      $display("FAIL to_len: enter high %0d clocks, expected 8", high_cnt);
    end
    tests_run++;
    if (rejected !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL to_reject: rejected=%b busy=%b expected 1 1", rejected, busy);
    end
    tick();
    tests_run++;
    if (rejected !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL to_select: rejected=%b busy=%b expected 0 0", rejected, busy);
    end
    repeat (6) tick();
    btn_up = 1'b1; repeat (6) tick(); btn_up = 1'b0; repeat (8) tick();
    tests_run++;
    if (move !== 3'd2) begin
      fails++;
      $display("FAIL to_up_after: move=%0d expected 2", move);
    end
  endtask

  task automatic test_present_ignore_gameover();
    ready = 1'b1;
    btn_go = 1'b1;
    repeat (6) tick();
    btn_go = 1'b0;
    btn_up = 1'b1;
    repeat (6) tick();
    btn_up = 1'b0;
    tests_run++;
    if (move !== 3'd2 || enter !== 1'b1) begin
      fails++;
      $display("FAIL pr_up_ignored: move=%0d enter=%b expected 2 1", move, enter);
    end
    gameover = 1'b1;
    tick();
    tests_run++;
    if (move !== 3'd1) begin
      fails++;
      $display("FAIL pr_gameover: move=%0d expected 1", move);
    end
    repeat (4) tick();
    gameover = 1'b0;
    repeat (8) tick();
    tests_run++;
    if (busy !== 1'b0 || move !== 3'd1) begin
      fails++;
      $display("FAIL pr_after: busy=%b move=%0d expected 0 1", busy, move);
    end
  endtask

  task automatic test_async_reset();
    ready = 1'b1;
    btn_go = 1'b1;
    repeat (6) tick();
    btn_go = 1'b0;
    tests_run++;
    if (enter !== 1'b1) begin
      fails++;
      $display("FAIL ar_pre: enter=%b expected 1", enter);
    end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (enter !== 1'b0 || busy !== 1'b0 || move !== 3'd1) begin
      fails++;
      $display("FAIL ar_drop: enter=%b busy=%b move=%0d expected 0 0 1", enter, busy, move);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_up_presses();
    test_saturation();
    test_glitch();
    test_handshake();
    test_timeout();
    test_present_ignore_gameover();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
